apb2axi_issue_sched: RTL
========================

APB2AXI_ISSUE_SCHED -- requirements
Module: apb2axi_issue_sched

Interface
REQ-001 SHALL have parameter ENTRY_W, default REQ_WIDTH: width of one packed directory_entry_t.
REQ-002 SHALL have parameter MAX_OUT_WR, default 4: maximum outstanding writes.
REQ-003 SHALL have parameter MAX_OUT_RD, default 4: maximum outstanding reads.
REQ-004 SHALL have ports (CW = $clog2(MAX_OUT_x+1)):
- aclk  in  1  single clock; all logic on its rising edge
- areset  in  1  synchronous, active-high reset
- wr_fifo_valid  in  1  WR request FIFO non-empty
- wr_fifo_data  in  ENTRY_W  WR FIFO head entry
- wr_fifo_pop  out  1  pop WR FIFO head this cycle
- rd_fifo_valid  in  1  RD request FIFO non-empty
- rd_fifo_data  in  ENTRY_W  RD FIFO head entry
- rd_fifo_pop  out  1  pop RD FIFO head this cycle
- hold  in  1  suppress new grants (drain/pause)
- issue_valid  out  1  registered entry offered to AXI address builder
- issue_ready  in  1  address builder accepts entry
- issue_data  out  ENTRY_W  offered entry
- issue_is_write  out  1  offered entry is a write
- wr_done  in  1  one write completed (B handshake)
- rd_done  in  1  one read completed (last R beat)
- wr_outstanding  out  CW(WR)  writes granted and not completed
- rd_outstanding  out  CW(RD)  reads granted and not completed
- idle  out  1  nothing held, nothing outstanding
- cnt_err  out  1  sticky: done pulse received with counter at zero

Function
REQ-005 SHALL implement two states: EMPTY (no entry held) and FULL (entry held in output register).
REQ-006 Eligibility: wr_elig = wr_fifo_valid && wr_outstanding < MAX_OUT_WR && !hold; rd_elig likewise; computed from registered counter values only.
REQ-007 A grant SHALL occur in a cycle where (state==EMPTY or (state==FULL and issue_valid && issue_ready)) and at least one requester is eligible.
REQ-008 Arbitration: if only one eligible, grant it; if both, grant the one not granted last (round-robin bit last_wr updated on every grant).
REQ-009 On grant, the matching *_fifo_pop SHALL be 1 combinationally that cycle (never both); head data captured into issue_data/issue_is_write at the next edge; state -> FULL.
REQ-010 Latency: fifo_valid asserted with FIFO head eligible in EMPTY -> issue_valid high next cycle; sustained throughput one entry per cycle while issue_ready=1.
REQ-011 issue_valid, issue_data, issue_is_write SHALL remain stable while issue_valid && !issue_ready.
REQ-012 FULL with handshake and no grant -> EMPTY, issue_valid=0 next cycle.
REQ-013 Outstanding counter SHALL increment on grant of its direction and decrement on its *_done; simultaneous grant and done leaves it unchanged.
REQ-014 Counter at MAX blocks grants of that direction, even if *_done is pulsed the same cycle (resumes next cycle).
REQ-015 *_done with counter at zero SHALL leave counter at zero and set cnt_err until reset.
REQ-016 hold SHALL not drop or alter an already-held entry; it is still offered.
REQ-017 idle = (state==EMPTY) && wr_outstanding==0 && rd_outstanding==0, combinational from registers.

Reset
REQ-018 On areset at a clock edge: state EMPTY, issue_valid 0, issue_data 0, issue_is_write 0, both counters 0, cnt_err 0, last_wr 0 (first tie goes to write).
REQ-019 Reset mid-operation SHALL discard any held entry; *_fifo_pop SHALL be 0 while areset is high.

Structure
REQ-020 MAX_OUT_WR/MAX_OUT_RD defaults and the sched state enum SHALL live in apb2axi_pkg alongside directory_entry_t.
REQ-021 Counter logic SHALL be one sub-module apb2axi_credit_cnt (inc, dec, count, at_max, underflow), instantiated twice.

Verification
REQ-022 Single write: wr_fifo_valid=1 one cycle, issue_ready=1 -> wr_fifo_pop 1 cycle, issue_valid next cycle with is_write=1, wr_outstanding=1; wr_done -> 0, idle=1.
REQ-023 Both FIFOs valid continuously, issue_ready=1 -> grants alternate W,R,W,R starting with W.
REQ-024 Five writes, no wr_done -> exactly 4 pops; 5th pops the cycle after first wr_done.
REQ-025 issue_ready=0 for 3 cycles with entry held -> issue_data stable, no pops; ready=1 -> handshake and next grant same cycle.
REQ-026 rd_done at rd_outstanding=0 -> counter stays 0, cnt_err=1 until areset; areset with entry held -> issue_valid=0 next cycle.

Source files
------------

// File: rtl/apb2axi_pkg.sv
`default_nettype none
// ============================================================================
// apb2axi_pkg : shared entry type, outstanding limits and scheduler states
// Rev 1.0
// ============================================================================
package apb2axi_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [4:0]  tag;
   } directory_entry_t;

   localparam int REQ_WIDTH      = $bits(directory_entry_t);
   localparam int DEF_MAX_OUT_WR = 4;
   localparam int DEF_MAX_OUT_RD = 4;

   typedef enum logic {
      SCHED_EMPTY = 1'b0,
      SCHED_FULL  = 1'b1
   } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/apb2axi_credit_cnt.sv
`default_nettype none
// ============================================================================
// apb2axi_credit_cnt : saturating outstanding-transaction counter, sticky underflow
// Rev 1.0
// ============================================================================
module apb2axi_credit_cnt
   import apb2axi_pkg::*;
#(
   parameter int MAX = DEF_MAX_OUT_WR,
   parameter int CW  = $clog2(MAX + 1)
) (
   input  logic          aclk,
   input  logic          areset,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          at_max,
   output logic          underflow
);

   localparam logic [CW-1:0] C_MAX = CW'(MAX);

   logic [CW-1:0] count_d, count_q;
   logic          underflow_d, underflow_q;

   always_comb begin
      count_d     = count_q;
      underflow_d = underflow_q;
      // A completion with nothing outstanding is a protocol error; never wrap.
      if (dec && (count_q == '0)) begin
         underflow_d = 1'b1;
      end
      if (inc && !dec) begin
         count_d = count_q + CW'(1);
      end else if (dec && !inc && (count_q != '0)) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         count_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   assign count     = count_q;
   assign at_max    = (count_q == C_MAX);
   assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: rtl/apb2axi_issue_sched.sv
`default_nettype none
// ============================================================================
// apb2axi_issue_sched : round-robin WR/RD grant into a one-entry issue register
// Rev 1.0
// ============================================================================
module apb2axi_issue_sched
   import apb2axi_pkg::*;
#(
   parameter int ENTRY_W    = REQ_WIDTH,
   parameter int MAX_OUT_WR = DEF_MAX_OUT_WR,
   parameter int MAX_OUT_RD = DEF_MAX_OUT_RD
) (
   input  logic                                aclk,
   input  logic                                areset,
   input  logic                                wr_fifo_valid,
   input  logic [ENTRY_W-1:0]                  wr_fifo_data,
   output logic                                wr_fifo_pop,
   input  logic                                rd_fifo_valid,
   input  logic [ENTRY_W-1:0]                  rd_fifo_data,
   output logic                                rd_fifo_pop,
   input  logic                                hold,
   output logic                                issue_valid,
   input  logic                                issue_ready,
   output logic [ENTRY_W-1:0]                  issue_data,
   output logic                                issue_is_write,
   input  logic                                wr_done,
   input  logic                                rd_done,
   output logic [$clog2(MAX_OUT_WR+1)-1:0]     wr_outstanding,
   output logic [$clog2(MAX_OUT_RD+1)-1:0]     rd_outstanding,
   output logic                                idle,
   output logic                                cnt_err
);

   sched_state_e       state_d, state_q;
   logic               last_wr_d, last_wr_q;
   logic [ENTRY_W-1:0] issue_data_d, issue_data_q;
   logic               issue_is_write_d, issue_is_write_q;

   logic wr_at_max, rd_at_max, wr_uflow, rd_uflow;
   logic wr_elig, rd_elig, slot_free, grant_wr, grant_rd;

   always_comb begin
      state_d          = state_q;
      last_wr_d        = last_wr_q;
      issue_data_d     = issue_data_q;
      issue_is_write_d = issue_is_write_q;

      wr_elig   = wr_fifo_valid && !wr_at_max && !hold;
      rd_elig   = rd_fifo_valid && !rd_at_max && !hold;
      slot_free = (state_q == SCHED_EMPTY) || ((state_q == SCHED_FULL) && issue_ready);
      // On a tie the direction not granted last wins.
      grant_wr  = !areset && slot_free && wr_elig && (!rd_elig || !last_wr_q);
      grant_rd  = !areset && slot_free && rd_elig && (!wr_elig || last_wr_q);

      if (grant_wr || grant_rd) begin
         state_d          = SCHED_FULL;
         issue_data_d     = grant_wr ? wr_fifo_data : rd_fifo_data;
         issue_is_write_d = grant_wr;
         last_wr_d        = grant_wr;
      end else if ((state_q == SCHED_FULL) && issue_ready) begin
         state_d = SCHED_EMPTY;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q          <= SCHED_EMPTY;
         last_wr_q        <= 1'b0;
         issue_data_q     <= '0;
         issue_is_write_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_wr_q        <= last_wr_d;
         issue_data_q     <= issue_data_d;
         issue_is_write_q <= issue_is_write_d;
      end
   end

   apb2axi_credit_cnt #(.MAX(MAX_OUT_WR)) u_wr_cnt (
      .aclk      (aclk),
      .areset    (areset),
      .inc       (grant_wr),
      .dec       (wr_done),
      .count     (wr_outstanding),
      .at_max    (wr_at_max),
      .underflow (wr_uflow)
   );

   apb2axi_credit_cnt #(.MAX(MAX_OUT_RD)) u_rd_cnt (
      .aclk      (aclk),
      .areset    (areset),
      .inc       (grant_rd),
      .dec       (rd_done),
      .count     (rd_outstanding),
      .at_max    (rd_at_max),
      .underflow (rd_uflow)
   );

   assign wr_fifo_pop    = grant_wr;
   assign rd_fifo_pop    = grant_rd;
   assign issue_valid    = (state_q == SCHED_FULL);
   assign issue_data     = issue_data_q;
   assign issue_is_write = issue_is_write_q;
   assign cnt_err        = wr_uflow || rd_uflow;
   assign idle           = (state_q == SCHED_EMPTY) && (wr_outstanding == '0) && (rd_outstanding == '0);

endmodule
`default_nettype wire
